// File: rtl/uart_baudrate_tick_gen_if.sv
// Interface bundling the enable inputs and tick outputs of the baud-rate tick generator.
//   I_baudrate_tx_clk_en : enable for the TX bit-rate tick counter
//   I_baudrate_rx_clk_en : enable for the RX oversampling tick counter
//   O_baudrate_tx_clk    : one-cycle TX bit tick
//   O_baudrate_rx_clk    : one-cycle RX oversample tick
// master drives the enables and consumes the ticks; slave is the generator side.
interface uart_baudrate_tick_gen_if;
  logic I_baudrate_tx_clk_en;
  logic I_baudrate_rx_clk_en;
  logic O_baudrate_tx_clk;
  logic O_baudrate_rx_clk;

  modport master (
    output I_baudrate_tx_clk_en,
    output I_baudrate_rx_clk_en,
    input  O_baudrate_tx_clk,
    input  O_baudrate_rx_clk
  );

  modport slave (
    input  I_baudrate_tx_clk_en,
    input  I_baudrate_rx_clk_en,
    output O_baudrate_tx_clk,
    output O_baudrate_rx_clk
  );
endinterface

// File: rtl/uart_baudrate_tick_gen.sv
// Baud-rate tick generator: produces a TX bit-rate strobe (one per bit period) and an RX
// oversampling strobe (OVERSAMPLE per bit period). Both are registered clock-enable pulses,
// one clk wide, and run only while their enable is high; a low enable clears the channel.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset, priority over the enables
//   bus   : slave modport carrying the two enables and the two tick outputs
module uart_baudrate_tick_gen #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_baudrate_tick_gen_if.slave  bus
);

  // Rounded clocks-per-bit and clocks-per-oversample.
  localparam int unsigned TX_DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int unsigned RX_DIV =
      (CLK_FREQ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);

  localparam int unsigned TX_W = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam int unsigned RX_W = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;

  if (TX_DIV < 1) begin : gen_tx_div_err
    $error("uart_baudrate_tick_gen: TX_DIV must be >= 1 (CLK_FREQ too low)");
  end
  if (RX_DIV < 1) begin : gen_rx_div_err
    $error("uart_baudrate_tick_gen: RX_DIV must be >= 1 (CLK_FREQ too low)");
  end

  localparam logic [TX_W-1:0] TX_LAST = TX_W'(TX_DIV - 1);
  localparam logic [RX_W-1:0] RX_LAST = RX_W'(RX_DIV - 1);

  logic [TX_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [RX_W-1:0] rx_cnt_q, rx_cnt_d;
  logic            tx_tick_q, tx_tick_d;
  logic            rx_tick_q, rx_tick_d;

  // A dropped enable wins over terminal count, so no partial or late tick escapes.
  always_comb begin
    tx_cnt_d  = '0;
    tx_tick_d = 1'b0;
    if (bus.I_baudrate_tx_clk_en) begin
      if (tx_cnt_q == TX_LAST) begin
        tx_tick_d = 1'b1;
      end else begin
        tx_cnt_d = tx_cnt_q + TX_W'(1);
      end
    end
  end

  always_comb begin
    rx_cnt_d  = '0;
    rx_tick_d = 1'b0;
    if (bus.I_baudrate_rx_clk_en) begin
      if (rx_cnt_q == RX_LAST) begin
        rx_tick_d = 1'b1;
      end else begin
        rx_cnt_d = rx_cnt_q + RX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      tx_tick_q <= 1'b0;
      rx_tick_q <= 1'b0;
    end else begin
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_tick_q <= tx_tick_d;
      rx_tick_q <= rx_tick_d;
    end
  end

  assign bus.O_baudrate_tx_clk = tx_tick_q;
  assign bus.O_baudrate_rx_clk = rx_tick_q;

endmodule

// File: tb/tb_uart_baudrate_tick_gen.sv
// Directed self-checking bench for uart_baudrate_tick_gen across three parameter sets:
//   u_a : CLK_FREQ=3200, BAUD_RATE=100   -> TX_DIV=32,  RX_DIV=2
//   u_d : defaults                        -> TX_DIV=434, RX_DIV=27
//   u_r : CLK_FREQ=1600, BAUD_RATE=100   -> TX_DIV=16,  RX_DIV=1
module tb_uart_baudrate_tick_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_baudrate_tick_gen_if if_a ();
  uart_baudrate_tick_gen_if if_d ();
  uart_baudrate_tick_gen_if if_r ();

  uart_baudrate_tick_gen #(
    .CLK_FREQ   (3200),
    .BAUD_RATE  (100),
    .OVERSAMPLE (16)
  ) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  uart_baudrate_tick_gen u_d (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_d.slave)
  );

  uart_baudrate_tick_gen #(
    .CLK_FREQ   (1600),
    .BAUD_RATE  (100),
    .OVERSAMPLE (16)
  ) u_r (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_r.slave)
  );

  localparam int SelATx = 0;
  localparam int SelARx = 1;
  localparam int SelDTx = 2;
  localparam int SelDRx = 3;
  localparam int SelRTx = 4;
  localparam int SelRRx = 5;

  logic [5:0] sig;
  assign sig = {if_r.O_baudrate_rx_clk, if_r.O_baudrate_tx_clk,
                if_d.O_baudrate_rx_clk, if_d.O_baudrate_tx_clk,
                if_a.O_baudrate_rx_clk, if_a.O_baudrate_tx_clk};

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the selected tick is seen; returns limit+1 if it never shows.
  task automatic wait_tick(input int sel, input int limit, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!sig[sel] && cyc <= limit);
  endtask

  // Runs n cycles on u_a, comparing every cycle against a period model (div 0 = no ticks).
  task automatic run_a(input int n, input int tx_div, input int rx_div,
                       output int ntx, output int nrx, output int perr);
    logic exp_tx, exp_rx;
    ntx  = 0;
    nrx  = 0;
    perr = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      exp_tx = (tx_div != 0) && (i % tx_div == 0);
      exp_rx = (rx_div != 0) && (i % rx_div == 0);
      if (if_a.O_baudrate_tx_clk) ntx++;
      if (if_a.O_baudrate_rx_clk) nrx++;
      if (if_a.O_baudrate_tx_clk !== exp_tx) perr++;
      if (if_a.O_baudrate_rx_clk !== exp_rx) perr++;
    end
  endtask

  task automatic set_a(input logic tx, input logic rx);
    if_a.I_baudrate_tx_clk_en = tx;
    if_a.I_baudrate_rx_clk_en = rx;
  endtask

  initial begin
    int cyc, ntx, nrx, perr, ntx2, nrx2, cnt;

    // Reset with enables high: outputs held low.
    rst_n = 1'b0;
    set_a(1'b1, 1'b1);
    if_d.I_baudrate_tx_clk_en = 1'b0;
    if_d.I_baudrate_rx_clk_en = 1'b0;
    if_r.I_baudrate_tx_clk_en = 1'b0;
    if_r.I_baudrate_rx_clk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_a_tx", int'(if_a.O_baudrate_tx_clk), 0);
      check_eq("rst_a_rx", int'(if_a.O_baudrate_rx_clk), 0);
      check_eq("rst_r_rx", int'(if_r.O_baudrate_rx_clk), 0);
    end
    if_r.I_baudrate_rx_clk_en = 1'b0;
    rst_n = 1'b1;
    wait_tick(SelATx, 40, cyc);
    check_eq("rst_release_first_tx", cyc, 32);

    // Continuous period: 200 cycles, split at a common multiple of both periods.
    set_a(1'b0, 1'b0);
    step();
    set_a(1'b1, 1'b1);
    run_a(32, 32, 2, ntx, nrx, perr);
    check_eq("period1_pos", perr, 0);
    check_eq("rx_per_tx", nrx, 16);
    run_a(168, 32, 2, ntx2, nrx2, perr);
    check_eq("period2_pos", perr, 0);
    check_eq("period_tx_count", ntx + ntx2, 6);
    check_eq("period_rx_count", nrx + nrx2, 100);

    // Enable dropped mid-count.
    set_a(1'b0, 1'b0);
    step();
    set_a(1'b1, 1'b0);
    run_a(20, 32, 0, ntx, nrx, perr);
    check_eq("dis_first20_pos", perr, 0);
    set_a(1'b0, 1'b0);
    run_a(5, 0, 0, ntx, nrx, perr);
    check_eq("dis_off5_pos", perr, 0);
    set_a(1'b1, 1'b0);
    wait_tick(SelATx, 40, cyc);
    check_eq("dis_reenable_tx", cyc, 32);

    // Enable dropped on the terminal-count edge: no tick.
    run_a(31, 32, 0, ntx, nrx, perr);
    check_eq("term_pre_pos", perr, 0);
    set_a(1'b0, 1'b0);
    step();
    check_eq("term_drop_tx", int'(if_a.O_baudrate_tx_clk), 0);

    // Channel independence.
    set_a(1'b1, 1'b0);
    run_a(100, 32, 0, ntx, nrx, perr);
    check_eq("ind_tx_pos", perr, 0);
    check_eq("ind_tx_count", ntx, 3);
    check_eq("ind_tx_rx_quiet", nrx, 0);
    set_a(1'b0, 1'b1);
    run_a(100, 0, 2, ntx, nrx, perr);
    check_eq("ind_rx_pos", perr, 0);
    check_eq("ind_rx_count", nrx, 50);
    check_eq("ind_rx_tx_quiet", ntx, 0);

    // Reset pulse at TX count 20.
    set_a(1'b0, 1'b0);
    step();
    set_a(1'b1, 1'b0);
    run_a(20, 32, 0, ntx, nrx, perr);
    check_eq("rmid_pre_pos", perr, 0);
    rst_n = 1'b0;
    step();
    check_eq("rmid_tx_low", int'(if_a.O_baudrate_tx_clk), 0);
    rst_n = 1'b1;
    wait_tick(SelATx, 40, cyc);
    check_eq("rmid_next_tx", cyc, 32);
    set_a(1'b0, 1'b0);

    // RX_DIV == 1: tick every cycle while enabled.
    if_r.I_baudrate_rx_clk_en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sig[SelRRx]) cnt++;
    end
    check_eq("div1_rx_count", cnt, 10);
    check_eq("div1_tx_quiet", int'(sig[SelRTx]), 0);
    if_r.I_baudrate_rx_clk_en = 1'b0;
    step();
    check_eq("div1_rx_off", int'(sig[SelRRx]), 0);

    // Default parameters: 434 / 27.
    if_d.I_baudrate_tx_clk_en = 1'b1;
    if_d.I_baudrate_rx_clk_en = 1'b1;
    wait_tick(SelDRx, 40, cyc);
    check_eq("def_rx_first", cyc, 27);
    wait_tick(SelDRx, 40, cyc);
    check_eq("def_rx_period", cyc, 27);
    wait_tick(SelDTx, 500, cyc);
    check_eq("def_tx_first", cyc, 380);
    wait_tick(SelDTx, 500, cyc);
    check_eq("def_tx_period", cyc, 434);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
